aftab_seq_multiplier: RTL and testbench

//  Iterative shift-and-add multiplier that drives aftab_adder each cycle with partial product and multiplicand.

---
 rtl/aftab_mul_pkg.sv | 9 +
 rtl/aftab_adder.sv | 16 +
 rtl/aftab_seq_multiplier.sv | 138 +++++++++++++
 tb/tb_aftab_seq_multiplier.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/aftab_mul_pkg.sv
// Shared definitions for the AFTAB sequential multiplier: FSM state encoding.
package aftab_mul_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CALC    = 2'd1,
        SIGNFIX = 2'd2,
        DONE    = 2'd3
    } mul_state_e;
endpackage

// File: rtl/aftab_adder.sv
// size-bit adder with carry in/out, shared by the multiplier's accumulate and negate steps.
module aftab_adder #(
    parameter int size = 32
) (
    input  logic [size-1:0] i_a,
    input  logic [size-1:0] i_b,
    input  logic            i_cin,
    output logic [size-1:0] o_sum,
    output logic            o_cout
);
    logic [size:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{size{1'b0}}, i_cin};
    assign o_sum  = w_full[size-1:0];
    assign o_cout = w_full[size];
endmodule

// File: rtl/aftab_seq_multiplier.sv
// Iterative shift-and-add multiplier, one partial-product step per cycle.
// Optional two's complement operands when AFTAB_MUL_SIGNED_EN is defined.
module aftab_seq_multiplier
    import aftab_mul_pkg::*;
#(
    parameter int size = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [size-1:0]   a,
    input  logic [size-1:0]   b,
`ifdef AFTAB_MUL_SIGNED_EN
    input  logic              a_signed,
    input  logic              b_signed,
`endif
    output logic              busy,
    output logic              done,
    output logic [2*size-1:0] result
);
    localparam int CW = $clog2(size + 1);

    mul_state_e         r_state, w_next;
    logic [size-1:0]    r_mcand;
    logic [2*size-1:0]  r_p;
    logic [CW-1:0]      r_count;
    logic [2*size-1:0]  r_result;

    logic [size-1:0]    w_add_a, w_add_b, w_sum;
    logic               w_add_cin, w_cout;
    logic [2*size-1:0]  w_p_calc;
    logic [size-1:0]    w_a_mag, w_b_mag;
    logic               w_last;

`ifdef AFTAB_MUL_SIGNED_EN
    localparam logic [size-1:0] ONE = size'(1);
    logic               r_neg;
    logic [2*size-1:0]  w_p_fix;
    logic [size-1:0]    w_lo_neg;

    // Operands flagged signed with MSB set are replaced by their magnitude.
    assign w_a_mag  = (a_signed && a[size-1]) ? (~a + ONE) : a;
    assign w_b_mag  = (b_signed && b[size-1]) ? (~b + ONE) : b;
    assign w_lo_neg = ~r_p[size-1:0] + ONE;
    // Upper half of ~P+1 goes through the adder; its carry-in is the low half's carry-out.
    assign w_p_fix  = r_neg ? {w_sum, w_lo_neg} : r_p;
`else
    assign w_a_mag = a;
    assign w_b_mag = b;
`endif

    assign w_last   = (r_count == CW'(1));
    assign w_p_calc = {w_cout, w_sum, r_p[size-1:1]};

    always_comb begin
        w_add_a   = r_p[2*size-1:size];
        w_add_b   = r_p[0] ? r_mcand : '0;
        w_add_cin = 1'b0;
`ifdef AFTAB_MUL_SIGNED_EN
        if (r_state == SIGNFIX) begin
            w_add_a   = ~r_p[2*size-1:size];
            w_add_b   = '0;
            w_add_cin = (r_p[size-1:0] == '0);
        end
`endif
    end

    aftab_adder #(.size(size)) u_adder (
        .i_a   (w_add_a),
        .i_b   (w_add_b),
        .i_cin (w_add_cin),
        .o_sum (w_sum),
        .o_cout(w_cout)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (start) w_next = CALC;
            CALC: if (w_last) begin
`ifdef AFTAB_MUL_SIGNED_EN
                w_next = SIGNFIX;
`else
                w_next = DONE;
`endif
            end
`ifdef AFTAB_MUL_SIGNED_EN
            SIGNFIX: w_next = DONE;
`endif
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_mcand  <= '0;
            r_p      <= '0;
            r_count  <= '0;
            r_result <= '0;
`ifdef AFTAB_MUL_SIGNED_EN
            r_neg    <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: if (start) begin
                    r_mcand <= w_a_mag;
                    r_p     <= {{size{1'b0}}, w_b_mag};
                    r_count <= CW'(size);
`ifdef AFTAB_MUL_SIGNED_EN
                    r_neg   <= (a_signed & a[size-1]) ^ (b_signed & b[size-1]);
`endif
                end
                CALC: begin
                    r_p     <= w_p_calc;
                    r_count <= r_count - CW'(1);
`ifndef AFTAB_MUL_SIGNED_EN
                    // Latch on entry to DONE so result is valid alongside the done pulse.
                    if (w_last) r_result <= w_p_calc;
`endif
                end
`ifdef AFTAB_MUL_SIGNED_EN
                SIGNFIX: begin
                    r_p      <= w_p_fix;
                    r_result <= w_p_fix;
                end
`endif
                default: ;
            endcase
        end
    end

    assign busy   = (r_state == CALC) || (r_state == SIGNFIX);
    assign done   = (r_state == DONE);
    assign result = r_result;
endmodule

// File: tb/tb_aftab_seq_multiplier.sv
// Randomized and directed checks of aftab_seq_multiplier at size=4 and size=32 against a cycle-level model.
module tb_aftab_seq_multiplier;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st [2];
    logic [31:0] av [2];
    logic [31:0] bv [2];
    logic        sa [2];
    logic        sb [2];
    logic        bsy [2];
    logic        dn [2];
    logic [63:0] res [2];
    int          nacc [2];
    int          dcount [2];
    int          n_vec = 0;
    int          n_err = 0;

`ifdef AFTAB_MUL_SIGNED_EN
    localparam int LAT4 = 6;
`else
    localparam int LAT4 = 5;
`endif

    always #5 clk = ~clk;

    function automatic logic [63:0] mprod(input logic [31:0] x, input logic [31:0] y,
                                          input bit xs, input bit ys, input int sz);
        logic [31:0] msk;
        longint      vx, vy;
        logic [63:0] p;
        msk = (sz == 32) ? 32'hFFFF_FFFF : ((32'd1 << sz) - 32'd1);
        vx = longint'({32'd0, x & msk});
        vy = longint'({32'd0, y & msk});
        if (xs && x[sz-1]) vx = vx - (longint'(1) << sz);
        if (ys && y[sz-1]) vy = vy - (longint'(1) << sz);
        p = 64'(vx * vy);
        if (sz < 32) p = p & ((64'd1 << (2 * sz)) - 64'd1);
        return p;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int SZ = (g == 0) ? 4 : 32;
`ifdef AFTAB_MUL_SIGNED_EN
        localparam int LAT = SZ + 2;
`else
        localparam int LAT = SZ + 1;
`endif
        logic [2*SZ-1:0] r_loc;
        logic            b_loc, d_loc;
        bit              m_act = 0;
        int              m_j = 0;
        logic [63:0]     m_res = '0;
        logic [63:0]     m_exp = '0;

        aftab_seq_multiplier #(.size(SZ)) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .start   (st[g]),
            .a       (av[g][SZ-1:0]),
            .b       (bv[g][SZ-1:0]),
`ifdef AFTAB_MUL_SIGNED_EN
            .a_signed(sa[g]),
            .b_signed(sb[g]),
`endif
            .busy    (b_loc),
            .done    (d_loc),
            .result  (r_loc)
        );
        assign res[g] = 64'(r_loc);
        assign bsy[g] = b_loc;
        assign dn[g]  = d_loc;

        // Model: j counts edges since the accepting edge; done falls at j==LAT-1.
        initial begin
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    if (m_act && m_j < LAT) nacc[g]--;
                    m_act = 0;
                    m_res = '0;
                end else if (!m_act || m_j >= LAT) begin
                    m_act = 0;
                    if (st[g]) begin
                        m_act = 1;
                        m_j   = 0;
                        m_exp = mprod(av[g], bv[g], sa[g], sb[g], SZ);
                        nacc[g]++;
                    end
                end else begin
                    m_j++;
                    if (m_j == LAT - 1) m_res = m_exp;
                end
            end
        end

        initial begin
            bit eb, ed;
            forever begin
                @(negedge clk);
                eb = rst_n && m_act && (m_j <= LAT - 2);
                ed = rst_n && m_act && (m_j == LAT - 1);
                n_vec++;
                if (dn[g]) dcount[g]++;
                if (bsy[g] !== eb || dn[g] !== ed || (!eb && res[g] !== m_res)) begin
                    n_err++;
                    $display("FAIL size%0d cycle: busy=%b done=%b result=%h, expected busy=%b done=%b result=%h",
                             SZ, bsy[g], dn[g], res[g], eb, ed, m_res);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic go4(input logic [3:0] x, input logic [3:0] y, input bit xs, input bit ys,
                       input logic [7:0] lit, input string nm);
        int cyc;
        @(posedge clk); #1;
        av[0] = {28'd0, x}; bv[0] = {28'd0, y}; sa[0] = xs; sb[0] = ys; st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        cyc = 1;
        while (!dn[0] && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({nm, " latency"}, 64'(cyc), 64'(LAT4));
        chk({nm, " result"}, res[0], {56'd0, lit});
        @(posedge clk); #1;
    endtask

    initial begin
        int d0, cyc;
        for (int g = 0; g < 2; g++) begin
            st[g] = 0; av[g] = 0; bv[g] = 0; sa[g] = 0; sb[g] = 0;
            nacc[g] = 0; dcount[g] = 0;
        end
        #1;
        chk("reset busy", {63'd0, bsy[0]}, 64'd0);
        chk("reset result", res[0], 64'd0);
        #22 rst_n = 1'b1;

        go4(4'd15, 4'd15, 0, 0, 8'hE1, "15x15");
        go4(4'd0,  4'd9,  0, 0, 8'h00, "0x9");
        go4(4'd9,  4'd0,  0, 0, 8'h00, "9x0");
        go4(4'd1,  4'd1,  0, 0, 8'h01, "1x1");

        // Starts while busy and on the done cycle are dropped; the next cycle's start is taken.
        @(posedge clk); #1;
        av[0] = 32'd7; bv[0] = 32'd3; st[0] = 1'b1;
        d0 = dcount[0];
        for (int c = 1; c <= LAT4 + 2; c++) begin
            @(posedge clk); #1;
            st[0] = (c == 2 || c == LAT4 || c == LAT4 + 1);
            if (c == LAT4) begin
                chk("7x3 done", {63'd0, dn[0]}, 64'd1);
                chk("7x3 result", res[0], 64'h15);
            end
            if (c == LAT4 + 1) begin
                av[0] = 32'd1; bv[0] = 32'd1;
            end
        end
        chk("restart busy", {63'd0, bsy[0]}, 64'd1);
        cyc = 0;
        while (!dn[0] && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("restart result", res[0], 64'h01);
        chk("single done per start", 64'(dcount[0] - d0), 64'd1);
        @(posedge clk); #1;

        // Reset mid-run.
        @(posedge clk); #1;
        av[0] = 32'd12; bv[0] = 32'd11; st[0] = 1'b1;
        @(posedge clk); #1; st[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("reset mid busy", {63'd0, bsy[0]}, 64'd0);
        chk("reset mid done", {63'd0, dn[0]}, 64'd0);
        chk("reset mid result", res[0], 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); #2 rst_n = 1'b1;
        go4(4'd12, 4'd11, 0, 0, 8'h84, "12x11");

`ifdef AFTAB_MUL_SIGNED_EN
        go4(4'hD, 4'd5, 1, 0, 8'hF1, "-3x5");
        go4(4'hD, 4'hD, 1, 1, 8'h09, "-3x-3");
`endif

        // Random phase: both sizes, starts thrown at every cycle with corner operands mixed in.
        cyc = 0;
        while (nacc[1] < 1000 && cyc < 60000) begin
            @(posedge clk); #1;
            cyc++;
            for (int g = 0; g < 2; g++) begin
                st[g] = ($urandom_range(0, 2) == 0);
                case ($urandom_range(0, 7))
                    0:       av[g] = 32'd0;
                    1:       av[g] = 32'hFFFF_FFFF;
                    default: av[g] = $urandom;
                endcase
                case ($urandom_range(0, 7))
                    0:       bv[g] = 32'd0;
                    1:       bv[g] = 32'hFFFF_FFFF;
                    default: bv[g] = $urandom;
                endcase
`ifdef AFTAB_MUL_SIGNED_EN
                sa[g] = $urandom_range(0, 1) == 1;
                sb[g] = $urandom_range(0, 1) == 1;
`endif
            end
        end
        chk("random budget", 64'(nacc[1] >= 1000), 64'd1);
        st[0] = 0; st[1] = 0;
        repeat (40) @(posedge clk);
        #1;
        chk("done count size4", 64'(dcount[0]), 64'(nacc[0]));
        chk("done count size32", 64'(dcount[1]), 64'(nacc[1]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
